// File: rtl/nd_2to1_rr.sv
// Two-input round-robin merge node with four-phase req/ack channels and a one-deep buffer per input.
// Latency: input acked one edge after req; message on o0_* one edge after capture.
// Backpressure: a full buffer withholds its input ack; o0_* hold steady until the sink acks.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_2to1_rr #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
) (
    input  logic           i_clk,
    input  logic           reset,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req,
    output logic           i0_ack,
    input  logic [ASZ-1:0] i1_src,
    input  logic [ASZ-1:0] i1_dst,
    input  logic [DSZ-1:0] i1_dat,
    input  logic [RSZ-1:0] i1_red,
    input  logic           i1_req,
    output logic           i1_ack,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o0_req,
    input  logic           o0_ack,
    output logic           i0_err,
    output logic           i1_err
);

    localparam int MW  = 2 * ASZ + DSZ;
    localparam int NCH = (MW + RSZ - 1) / RSZ;

    typedef enum logic { IN_IDLE, IN_ACK } in_state_e;
    typedef enum logic [1:0] { OUT_IDLE, OUT_REQ, OUT_REL } out_state_e;

    // Redundancy is the XOR fold of {src, dst, dat} into RSZ-bit chunks (top chunk zero-padded).
    function automatic logic [RSZ-1:0] calc_redun(input logic [ASZ-1:0] s,
                                                  input logic [ASZ-1:0] d,
                                                  input logic [DSZ-1:0] x);
        logic [NCH*RSZ-1:0] v;
        logic [RSZ-1:0]     r;
        v         = '0;
        v[MW-1:0] = {s, d, x};
        r         = '0;
        for (int c = 0; c < NCH; c++) begin
            r = r ^ v[c*RSZ +: RSZ];
        end
        return r;
    endfunction

    logic [ASZ-1:0] in_src [2];
    logic [ASZ-1:0] in_dst [2];
    logic [DSZ-1:0] in_dat [2];
    logic [RSZ-1:0] in_red [2];
    logic [1:0]     in_req;

    assign in_src[0] = i0_src;
    assign in_src[1] = i1_src;
    assign in_dst[0] = i0_dst;
    assign in_dst[1] = i1_dst;
    assign in_dat[0] = i0_dat;
    assign in_dat[1] = i1_dat;
    assign in_red[0] = i0_red;
    assign in_red[1] = i1_red;
    assign in_req    = {i1_req, i0_req};

    in_state_e      in_state_q [2];
    in_state_e      in_state_d [2];
    logic [ASZ-1:0] buf_src_q [2];
    logic [ASZ-1:0] buf_src_d [2];
    logic [ASZ-1:0] buf_dst_q [2];
    logic [ASZ-1:0] buf_dst_d [2];
    logic [DSZ-1:0] buf_dat_q [2];
    logic [DSZ-1:0] buf_dat_d [2];
    logic [RSZ-1:0] buf_red_q [2];
    logic [RSZ-1:0] buf_red_d [2];
    logic [1:0]     ack_q, ack_d;
    logic [1:0]     err_q, err_d;
    logic [1:0]     full_q, full_d;
    logic [1:0]     cap, clr;

    out_state_e     out_state_q, out_state_d;
    logic [ASZ-1:0] o_src_q, o_src_d;
    logic [ASZ-1:0] o_dst_q, o_dst_d;
    logic [DSZ-1:0] o_dat_q, o_dat_d;
    logic [RSZ-1:0] o_red_q, o_red_d;
    logic           o_req_q, o_req_d;
    logic           last_q, last_d;
    logic           g;

    always_comb begin
        cap   = '0;
        ack_d = ack_q;
        err_d = err_q;
        for (int n = 0; n < 2; n++) begin
            in_state_d[n] = in_state_q[n];
            buf_src_d[n]  = buf_src_q[n];
            buf_dst_d[n]  = buf_dst_q[n];
            buf_dat_d[n]  = buf_dat_q[n];
            buf_red_d[n]  = buf_red_q[n];
            case (in_state_q[n])
                IN_IDLE: begin
                    if (in_req[n] && !full_q[n]) begin
                        cap[n]        = 1'b1;
                        buf_src_d[n]  = in_src[n];
                        buf_dst_d[n]  = in_dst[n];
                        buf_dat_d[n]  = in_dat[n];
                        buf_red_d[n]  = in_red[n];
                        ack_d[n]      = 1'b1;
                        in_state_d[n] = IN_ACK;
                        if (in_red[n] != calc_redun(in_src[n], in_dst[n], in_dat[n])) begin
                            err_d[n] = 1'b1;
                        end
                    end
                end
                IN_ACK: begin
                    if (!in_req[n]) begin
                        ack_d[n]      = 1'b0;
                        in_state_d[n] = IN_IDLE;
                    end
                end
                default: in_state_d[n] = IN_IDLE;
            endcase
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        o_src_d     = o_src_q;
        o_dst_d     = o_dst_q;
        o_dat_d     = o_dat_q;
        o_red_d     = o_red_q;
        o_req_d     = o_req_q;
        last_d      = last_q;
        clr         = '0;
        g           = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (|full_q) begin
                    g           = (&full_q) ? ~last_q : full_q[1];
                    o_src_d     = buf_src_q[g];
                    o_dst_d     = buf_dst_q[g];
                    o_dat_d     = buf_dat_q[g];
                    o_red_d     = buf_red_q[g];
                    o_req_d     = 1'b1;
                    last_d      = g;
                    out_state_d = OUT_REQ;
                end
            end
            OUT_REQ: begin
                // last_q still names the buffer being forwarded here.
                if (o0_ack) begin
                    o_req_d     = 1'b0;
                    clr[last_q] = 1'b1;
                    out_state_d = OUT_REL;
                end
            end
            OUT_REL: begin
                if (!o0_ack) begin
                    out_state_d = OUT_IDLE;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    // Set only while clear, cleared only while set: the two writers never collide.
    assign full_d = (full_q & ~clr) | cap;

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 2; n++) begin
                in_state_q[n] <= IN_IDLE;
                buf_src_q[n]  <= '0;
                buf_dst_q[n]  <= '0;
                buf_dat_q[n]  <= '0;
                buf_red_q[n]  <= '0;
            end
            ack_q       <= '0;
            err_q       <= '0;
            full_q      <= '0;
            out_state_q <= OUT_IDLE;
            o_src_q     <= '0;
            o_dst_q     <= '0;
            o_dat_q     <= '0;
            o_red_q     <= '0;
            o_req_q     <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            for (int n = 0; n < 2; n++) begin
                in_state_q[n] <= in_state_d[n];
                buf_src_q[n]  <= buf_src_d[n];
                buf_dst_q[n]  <= buf_dst_d[n];
                buf_dat_q[n]  <= buf_dat_d[n];
                buf_red_q[n]  <= buf_red_d[n];
            end
            ack_q       <= ack_d;
            err_q       <= err_d;
            full_q      <= full_d;
            out_state_q <= out_state_d;
            o_src_q     <= o_src_d;
            o_dst_q     <= o_dst_d;
            o_dat_q     <= o_dat_d;
            o_red_q     <= o_red_d;
            o_req_q     <= o_req_d;
            last_q      <= last_d;
        end
    end

    assign i0_ack = ack_q[0];
    assign i1_ack = ack_q[1];
    assign i0_err = err_q[0];
    assign i1_err = err_q[1];
    assign o0_src = o_src_q;
    assign o0_dst = o_dst_q;
    assign o0_dat = o_dat_q;
    assign o0_red = o_red_q;
    assign o0_req = o_req_q;

endmodule
